// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
// Upstream controller for an 8-to-1 mux stage. A word accepted over a
// valid/ready handshake is held on the mux data inputs while the select
// walks all eight positions. The mux output is sampled once per position
// into a serial bit stream. Together with the mux this forms a
// parallel-to-serial converter.

module mux_scan_sequencer #(
  parameter int   BIT_CYCLES = 1,     // clocks each select value is held, >= 1
  parameter logic MSB_FIRST  = 1'b0   // 0: select steps 0->7, 1: select steps 7->0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load_valid,
  output logic       o_load_ready,
  input  logic [7:0] i_load_data,
  input  logic       i_abort,
  output logic [7:0] o_mux_in,
  output logic [2:0] o_mux_sel,
  input  logic       i_mux_out,
  output logic       o_ser_data,
  output logic       o_ser_valid,
  output logic       o_ser_last,
  output logic       o_busy
);

  // Hold counter only needs to reach BIT_CYCLES-1; keep at least one bit.
  localparam int                HOLD_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(BIT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [2:0]        SEL_START = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0]        BIT_LAST  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [7:0]        r_mux_in;
  logic [2:0]        r_mux_sel;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [2:0]        r_bit_cnt;
  logic              r_ser_data;
  logic              r_ser_valid;
  logic              r_ser_last;
  logic              r_busy;
  logic              r_load_ready;

  logic              w_accept;
  logic              w_abort_active;
  logic              w_hold_done;
  logic              w_sample;
  logic              w_last_bit;
  logic [2:0]        w_sel_step;

  // Decode handshake, abort and sample-point conditions from current state.
  always_comb begin
    w_accept       = (r_state == ST_IDLE) && i_load_valid;
    w_abort_active = (r_state != ST_IDLE) && i_abort;
    w_hold_done    = (r_hold_cnt == HOLD_ZERO);
    // An abort on the sample edge suppresses the bit entirely.
    w_sample       = (r_state == ST_SHIFT) && w_hold_done && !i_abort;
    w_last_bit     = (r_bit_cnt == BIT_LAST);
    // 3-bit arithmetic wraps 7->0 (or 0->7) on the final step by design.
    if (MSB_FIRST) begin
      w_sel_step = r_mux_sel - 3'd1;
    end else begin
      w_sel_step = r_mux_sel + 3'd1;
    end
  end

  // Next-state logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        // Abort has no effect in IDLE; a simultaneous load is still taken.
        if (i_load_valid) begin
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (i_abort) begin
          w_next_state = ST_IDLE;
        end else if (w_sample && w_last_bit) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // Single turnaround cycle, abort or not.
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered status flags, derived from the next state so they track r_state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy       <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      r_busy       <= (w_next_state == ST_SHIFT) || (w_next_state == ST_DONE);
      r_load_ready <= (w_next_state == ST_IDLE);
    end
  end

  // Word latch: stable for the whole word, survives abort, changes only on accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mux_in <= 8'h00;
    end else if (w_accept) begin
      r_mux_in <= i_load_data;
    end else begin
      r_mux_in <= r_mux_in;
    end
  end

  // Select walker plus hold and bit counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mux_sel  <= SEL_START;
      r_hold_cnt <= HOLD_ZERO;
      r_bit_cnt  <= 3'd0;
    end else if (w_accept) begin
      r_mux_sel  <= SEL_START;
      r_hold_cnt <= HOLD_INIT;
      r_bit_cnt  <= 3'd0;
    end else if (w_abort_active) begin
      r_mux_sel  <= SEL_START;
      r_hold_cnt <= HOLD_ZERO;
      r_bit_cnt  <= 3'd0;
    end else if (r_state == ST_SHIFT) begin
      if (w_hold_done) begin
        r_mux_sel  <= w_sel_step;
        r_hold_cnt <= HOLD_INIT;
        r_bit_cnt  <= r_bit_cnt + 3'd1;
      end else begin
        r_mux_sel  <= r_mux_sel;
        r_hold_cnt <= r_hold_cnt - HOLD_ONE;
        r_bit_cnt  <= r_bit_cnt;
      end
    end else begin
      r_mux_sel  <= r_mux_sel;
      r_hold_cnt <= r_hold_cnt;
      r_bit_cnt  <= r_bit_cnt;
    end
  end

  // Serial output stage: capture the mux output on the last hold clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ser_data  <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
    end else if (w_sample) begin
      r_ser_data  <= i_mux_out;
      r_ser_valid <= 1'b1;
      r_ser_last  <= w_last_bit;
    end else begin
      r_ser_data  <= r_ser_data;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
    end
  end

  assign o_load_ready = r_load_ready;
  assign o_busy       = r_busy;
  assign o_mux_in     = r_mux_in;
  assign o_mux_sel    = r_mux_sel;
  assign o_ser_data   = r_ser_data;
  assign o_ser_valid  = r_ser_valid;
  assign o_ser_last   = r_ser_last;

endmodule
